regfile_bypass_clr: RTL and testbench

//  Parametrised 2-read/1-write integer register file for the five-stage pipeline.

---
 rtl/regfile_bypass_clr.sv | 170 +++++++++++++++++
 tb/tb_regfile_bypass_clr.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass_clr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_bypass_clr                                              |
// | Purpose  : 2-read/1-write integer register file for the five-stage         |
// |            pipeline, with same-cycle write-to-read bypass, a hardware      |
// |            clear sequencer that zeroes every entry after reset or on       |
// |            request, and a ready flag used by the hazard unit.              |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            clr_req          - one-cycle pulse, restarts the clear sweep    |
// |            we3/wa3/wd3      - write port (writeback stage)                 |
// |            ra1/ra2 -> rd1/rd2 - combinational read ports (decode stage)    |
// |            ready            - 1 once the clear sweep has finished          |
// |            wr_drop          - registered, 1 for a cycle after a discarded  |
// |                               write                                        |
// | Options  : REGFILE_SCOREBOARD_EN adds per-entry pending bits with ports    |
// |            iss_v/iss_rd (issue) and haz1/haz2 (pending[ra1]/pending[ra2]). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module regfile_bypass_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic              iss_v,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              haz1,
  output logic              haz2,
`endif
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              ready,
  output logic              wr_drop
);

  localparam int                DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [ADDR_W-1:0] w_clr_idx_nxt;
  logic              r_wr_drop;
  logic              w_wr_drop_nxt;
  logic [DATA_W-1:0] r_rf [DEPTH];
  logic              w_zero_wa;
  logic              w_wr_acc;

  // A write lands only in RUN, not in the cycle a clear is requested, and
  // never on the hard-wired zero entry.
  assign w_zero_wa = (ZERO_REG != 0) && (wa3 == '0);
  assign w_wr_acc  = (r_state == ST_RUN) && !clr_req && we3 && !w_zero_wa;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      r_wr_drop <= w_wr_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_wr_drop_nxt = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_wr_drop_nxt = we3;
        if (clr_req) begin
          w_clr_idx_nxt = '0;
        end else begin
          w_clr_idx_nxt = r_clr_idx + 1'b1;
          if (r_clr_idx == C_LAST_IDX) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_idx_nxt = '0;
          // A write in the request cycle is dropped, whatever its address.
          w_wr_drop_nxt = we3;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // Storage is deliberately not reset; the sweep zeroes it one entry per edge.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_rf[r_clr_idx] <= '0;
    end else if (w_wr_acc) begin
      r_rf[wa3] <= wd3;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              in_clear,
    input logic [ADDR_W-1:0] ra,
    input logic              acc,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (acc && (ra == wa)) v = wd;
    if ((ZERO_REG != 0) && (ra == '0)) v = '0;
    if (in_clear) v = '0;
    return v;
  endfunction

  assign rd1     = read_port(r_state == ST_CLEAR, ra1, w_wr_acc, wa3, wd3, r_rf[ra1]);
  assign rd2     = read_port(r_state == ST_CLEAR, ra2, w_wr_acc, wa3, wd3, r_rf[ra2]);
  assign ready   = (r_state == ST_RUN);
  assign wr_drop = r_wr_drop;

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pending_nxt;

  // Issue sets a bit after an accepted write clears it, so a same-cycle set
  // of the same entry wins.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
    if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
      assign w_pending_nxt[gi] = 1'b0;
    end else begin : g_bit
      assign w_pending_nxt[gi] =
          ((r_state == ST_CLEAR) || clr_req)           ? 1'b0 :
          (iss_v && (iss_rd == ADDR_W'(gi)))           ? 1'b1 :
          (w_wr_acc && (wa3 == ADDR_W'(gi)))           ? 1'b0 :
                                                         r_pending[gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign haz1 = r_pending[ra1];
  assign haz2 = r_pending[ra2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_bypass_clr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_regfile_bypass_clr                                           |
// | Purpose  : Randomised, scoreboarded bench for regfile_bypass_clr. A        |
// |            driver issues stimulus and pushes the expected outputs of each  |
// |            cycle; a monitor pops and compares on the falling edge.         |
// | Options  : REGFILE_SCOREBOARD_EN also checks haz1/haz2.                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_regfile_bypass_clr;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          clr_req = 1'b0;
  logic          we3     = 1'b0;
  logic [AW-1:0] wa3     = '0;
  logic [DW-1:0] wd3     = '0;
  logic [AW-1:0] ra1     = '0;
  logic [AW-1:0] ra2     = '0;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          ready;
  logic          wr_drop;
`ifdef REGFILE_SCOREBOARD_EN
  logic          iss_v  = 1'b0;
  logic [AW-1:0] iss_rd = '0;
  logic          haz1;
  logic          haz2;
`endif

  regfile_bypass_clr #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .we3     (we3),
    .wa3     (wa3),
    .wd3     (wd3),
    .ra1     (ra1),
    .ra2     (ra2),
`ifdef REGFILE_SCOREBOARD_EN
    .iss_v   (iss_v),
    .iss_rd  (iss_rd),
    .haz1    (haz1),
    .haz2    (haz2),
`endif
    .rd1     (rd1),
    .rd2     (rd2),
    .ready   (ready),
    .wr_drop (wr_drop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          ready;
    logic          wr_drop;
    logic          haz1;
    logic          haz2;
  } exp_t;

  exp_t sbq[$];

  // Reference model: architectural contents, remaining sweep length, the
  // registered drop flag and the pending set.
  logic [DW-1:0] mem  [DEPTH];
  logic          pend [DEPTH];
  int            clear_left;
  logic          m_drop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic accepted(input logic c, input logic w, input logic [AW-1:0] a);
    return (clear_left == 0) && !c && w && (a != 0);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] ra);
    if (clear_left > 0) return '0;
    if (ra == 0) return '0;
    if (accepted(clr_req, we3, wa3) && ra == wa3) return wd3;
    return mem[ra];
  endfunction

  task automatic model_reset();
    clear_left = DEPTH;
    m_drop     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      pend[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic c, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic iv, input logic [AW-1:0] ir);
    logic acc;
    acc    = accepted(c, w, a);
    m_drop = w && ((clear_left > 0) || c);
    if (c || clear_left > 0) begin
      for (int i = 0; i < DEPTH; i++) pend[i] = 1'b0;
    end else begin
      if (acc) pend[a] = 1'b0;
      if (iv) pend[ir] = 1'b1;
      pend[0] = 1'b0;
    end
    if (acc) mem[a] = d;
    if (c) begin
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end else if (clear_left > 0) begin
      clear_left--;
    end
  endtask

  task automatic step(input logic c, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [AW-1:0] r1,
                      input logic [AW-1:0] r2, input logic iv, input logic [AW-1:0] ir);
    exp_t e;
    clr_req = c; we3 = w; wa3 = a; wd3 = d; ra1 = r1; ra2 = r2;
`ifdef REGFILE_SCOREBOARD_EN
    iss_v = iv; iss_rd = ir;
`endif
    e.rd1     = m_read(r1);
    e.rd2     = m_read(r2);
    e.ready   = (clear_left == 0);
    e.wr_drop = m_drop;
    e.haz1    = pend[r1];
    e.haz2    = pend[r2];
    sbq.push_back(e);
    @(posedge clk);
    model_edge(c, w, a, d, iv, ir);
    #1;
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    chk("ready_async_reset", {63'd0, ready}, 64'd0);
    chk("wr_drop_async_reset", {63'd0, wr_drop}, 64'd0);
    model_reset();
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("ready", {63'd0, ready}, {63'd0, e.ready});
      chk("wr_drop", {63'd0, wr_drop}, {63'd0, e.wr_drop});
      chk("rd1", {32'd0, rd1}, {32'd0, e.rd1});
      chk("rd2", {32'd0, rd2}, {32'd0, e.rd2});
`ifdef REGFILE_SCOREBOARD_EN
      chk("haz1", {63'd0, haz1}, {63'd0, e.haz1});
      chk("haz2", {63'd0, haz2}, {63'd0, e.haz2});
`endif
    end
  end

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic          rr;

    do_reset(2);

    // Write held during the whole sweep: dropped every cycle, ready after 32 edges.
    for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 5'd5, 32'hAA, 5'd5, 5'd0, 0, 0);

    // Bypass then retained value.
    step(0, 1, 5'd7, 32'h1234, 5'd7, 5'd7, 0, 0);
    step(0, 0, 5'd0, 32'h0, 5'd7, 5'd5, 0, 0);

    // Write to the zero entry.
    step(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 0, 0);
    step(0, 0, 5'd0, 32'h0, 5'd0, 5'd7, 0, 0);

    // Fill, then clear request with a colliding write.
    for (int i = 1; i < DEPTH; i++) step(0, 1, AW'(i), DW'(i), AW'(i), AW'(i - 1), 0, 0);
    step(1, 1, 5'd3, 32'hDEAD, 5'd3, 5'd4, 0, 0);
    for (int i = 0; i < DEPTH + 3; i++) step(0, 0, 5'd0, 32'h0, AW'(i), AW'(DEPTH - 1 - i), 0, 0);

    // Reset in the middle of a sweep (index 10).
    step(1, 0, 5'd0, 32'h0, 5'd1, 5'd2, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 5'd0, 32'h0, 5'd1, 5'd2, 0, 0);
    do_reset(1);
    for (int i = 0; i < DEPTH + 2; i++) step(0, i[0], 5'd9, 32'h99, 5'd9, 5'd1, 0, 0);

    // Issue and write of the same register in one cycle.
    step(0, 0, 5'd0, 32'h0, 5'd4, 5'd0, 1, 5'd4);
    step(0, 1, 5'd4, 32'h44, 5'd4, 5'd0, 1, 5'd4);
    step(0, 0, 5'd0, 32'h0, 5'd4, 5'd4, 0, 5'd0);

    // Randomised traffic with occasional clears and resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset($urandom_range(1, 3));
      a  = AW'($urandom);
      rr = ($urandom_range(0, 3) == 0);
      r1 = rr ? a : AW'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? a : AW'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, a, $urandom,
           r1, r2, $urandom_range(0, 3) == 0, AW'($urandom));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
